// File: rtl/fnd_scan_decoder.sv
// fnd_scan_decoder: rebuilds per-position digit values from a multiplexed,
// active-low 7-segment bus. It includes a stability filter for glitches and
// scan edges, and a watchdog for a display that has stopped refreshing.
//
// state  | meaning
// IDLE   | select bus not one-hot (blank or overlapping scan), nothing tracked
// TRACK  | one-hot pair seen, counting consecutive identical samples
// HOLD   | pair already captured, waiting for it to change
module fnd_scan_decoder #(
    parameter int NUM_DIG    = 4,
    parameter int STABLE_CYC = 4,
    parameter int TIMEOUT    = 50000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           seg_n,
    input  logic [NUM_DIG-1:0]   dig_sel_n,
    input  logic                 err_clr,
    output logic [4*NUM_DIG-1:0] digits,
    output logic [NUM_DIG-1:0]   dig_valid,
    output logic                 upd,
    output logic [2:0]           upd_idx,
    output logic                 err,
    output logic                 stale
);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_TRACK = 2'd1;
    localparam logic [1:0]  ST_HOLD  = 2'd2;
    localparam logic [7:0]  S_CYC    = 8'(STABLE_CYC);
    localparam logic [19:0] TO_CYC   = 20'(TIMEOUT);
    localparam logic [19:0] TO_M1    = 20'(TIMEOUT - 1);

    logic [6:0]         seg_m, seg_s, seg_p;
    logic [NUM_DIG-1:0] sel_m, sel_s, sel_p;
    logic [1:0]         state;
    logic [7:0]         cnt;
    logic [19:0]        wd;

    logic       same;
    logic       sel_onehot;
    logic       capture;
    logic [2:0] cap_idx;
    logic [3:0] cap_val;
    logic       wd_hit;

    function automatic logic is_onehot(input logic [NUM_DIG-1:0] sel);
        int n;
        n = 0;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (!sel[i]) n++;
        end
        return (n == 1);
    endfunction

    function automatic logic [2:0] low_index(input logic [NUM_DIG-1:0] sel);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NUM_DIG - 1; i >= 0; i--) begin
            if (!sel[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic [3:0] decode(input logic [6:0] seg);
        logic [3:0] val;
        case (seg)
            7'h40:   val = 4'h0;
            7'h79:   val = 4'h1;
            7'h24:   val = 4'h2;
            7'h30:   val = 4'h3;
            7'h19:   val = 4'h4;
            7'h12:   val = 4'h5;
            7'h02:   val = 4'h6;
            7'h58:   val = 4'h7;
            7'h00:   val = 4'h8;
            7'h10:   val = 4'h9;
            7'h7F:   val = 4'hF;
            default: val = 4'hE;
        endcase
        return val;
    endfunction

    // The capture uses the previous-cycle pair, which is the one that has
    // just been stable for STABLE_CYC samples, even if the bus moves now.
    always_comb begin
        same       = (sel_s == sel_p) && (seg_s == seg_p);
        sel_onehot = is_onehot(sel_s);
        capture    = (state == ST_TRACK) && (cnt == S_CYC);
        cap_idx    = low_index(sel_p);
        cap_val    = decode(seg_p);
        wd_hit     = !capture && (wd == TO_M1);
    end

    // Two-flop synchronizers and the previous-sample pair, all idle-high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_m <= '1;
            seg_s <= '1;
            seg_p <= '1;
            sel_m <= '1;
            sel_s <= '1;
            sel_p <= '1;
        end else begin
            seg_m <= seg_n;
            seg_s <= seg_m;
            seg_p <= seg_s;
            sel_m <= dig_sel_n;
            sel_s <= sel_m;
            sel_p <= sel_s;
        end
    end

    // Stability filter FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= 8'd0;
        end else if (!same) begin
            state <= sel_onehot ? ST_TRACK : ST_IDLE;
            cnt   <= sel_onehot ? 8'd1 : 8'd0;
        end else begin
            case (state)
                ST_TRACK: begin
                    if (capture) state <= ST_HOLD;
                    else         cnt   <= cnt + 8'd1;
                end
                ST_HOLD: state <= ST_HOLD;
                default: begin
                    state <= ST_IDLE;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end

    // Watchdog counter, saturating at TIMEOUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             wd <= 20'd0;
        else if (capture)       wd <= 20'd0;
        else if (wd != TO_CYC)  wd <= wd + 20'd1;
    end

    // Captured outputs, validity and stale tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits    <= '0;
            dig_valid <= '0;
            upd       <= 1'b0;
            upd_idx   <= 3'd0;
            stale     <= 1'b0;
        end else begin
            upd <= capture;
            if (capture) begin
                upd_idx <= cap_idx;
                stale   <= 1'b0;
                for (int i = 0; i < NUM_DIG; i++) begin
                    if (cap_idx == 3'(i)) begin
                        digits[4*i +: 4] <= cap_val;
                        dig_valid[i]     <= 1'b1;
                    end
                end
            end else if (wd_hit) begin
                stale     <= 1'b1;
                dig_valid <= '0;
            end
        end
    end

    // Sticky glyph error; a new bad capture overrides a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else        err <= (err && !err_clr) || (capture && cap_val == 4'hE);
    end

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Bench for fnd_scan_decoder: vector table plus hand sequences, with a
// scoreboard of expected captures popped on every upd pulse.
module tb_fnd_scan_decoder;

    localparam int NUM_DIG    = 4;
    localparam int STABLE_CYC = 4;
    localparam int TIMEOUT    = 100;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [6:0]   seg_n = 7'h24;
    logic [3:0]   dig_sel_n = 4'b1110;
    logic         err_clr = 1'b0;
    logic [15:0]  digits;
    logic [3:0]   dig_valid;
    logic         upd;
    logic [2:0]   upd_idx;
    logic         err;
    logic         stale;

    int passed = 0;
    int total  = 0;

    typedef struct {
        int         idx;
        logic [3:0] val;
        logic       err;
    } exp_t;

    typedef struct {
        logic [3:0] sel_n;
        logic [6:0] seg_n;
        int         ncyc;
        bit         cap;
        int         idx;
        logic [3:0] val;
        logic       err;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[11];

    fnd_scan_decoder #(
        .NUM_DIG(NUM_DIG),
        .STABLE_CYC(STABLE_CYC),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .seg_n(seg_n),
        .dig_sel_n(dig_sel_n),
        .err_clr(err_clr),
        .digits(digits),
        .dig_valid(dig_valid),
        .upd(upd),
        .upd_idx(upd_idx),
        .err(err),
        .stale(stale)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Every upd pulse must match the oldest outstanding expected capture.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && upd === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                $display("FAIL unexpected_upd: got upd_idx %0d digits %0h expected no capture", upd_idx, digits);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("upd_idx", 32'(upd_idx), 32'(e.idx));
                chk("upd_digit", 32'(digits[4*e.idx +: 4]), 32'(e.val));
                chk("upd_valid_bit", 32'(dig_valid[e.idx]), 32'd1);
                chk("upd_err", 32'(err), 32'(e.err));
            end
        end
    end

    task automatic apply(input vec_t v);
        if (v.cap) sbq.push_back('{v.idx, v.val, v.err});
        dig_sel_n = v.sel_n;
        seg_n     = v.seg_n;
        repeat (v.ncyc) @(negedge clk);
    endtask

    task automatic wait_upd(input string name);
        int n;
        n = 0;
        while (upd !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n < 30), 32'd1);
    endtask

    initial begin
        vecs[0]  = '{4'b1110, 7'h79, 10, 1'b1, 0, 4'h1, 1'b0};
        vecs[1]  = '{4'b1101, 7'h30, 10, 1'b1, 1, 4'h3, 1'b0};
        vecs[2]  = '{4'b1011, 7'h12, 10, 1'b1, 2, 4'h5, 1'b0};
        vecs[3]  = '{4'b0111, 7'h58, 10, 1'b1, 3, 4'h7, 1'b0};
        vecs[4]  = '{4'b1101, 7'h00, STABLE_CYC - 1, 1'b0, 0, 4'h0, 1'b0};
        vecs[5]  = '{4'b1101, 7'h30, 10, 1'b1, 1, 4'h3, 1'b0};
        vecs[6]  = '{4'b1101, 7'h00, STABLE_CYC, 1'b1, 1, 4'h8, 1'b0};
        vecs[7]  = '{4'b1011, 7'h7F, 10, 1'b1, 2, 4'hF, 1'b0};
        vecs[8]  = '{4'b1100, 7'h00, 20, 1'b0, 0, 4'h0, 1'b0};
        vecs[9]  = '{4'b1111, 7'h00, 20, 1'b0, 0, 4'h0, 1'b0};
        vecs[10] = '{4'b0111, 7'h55, 10, 1'b1, 3, 4'hE, 1'b1};

        // Reset values with live inputs on the bus.
        repeat (3) @(negedge clk);
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_dig_valid", 32'(dig_valid), 32'h0);
        chk("rst_upd", 32'(upd), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_stale", 32'(stale), 32'h0);

        // First capture after release lands after 2 + STABLE_CYC edges.
        sbq.push_back('{0, 4'h2, 1'b0});
        rst_n = 1'b1;
        repeat (2 + STABLE_CYC) @(negedge clk);
        chk("latency_early", 32'(upd), 32'h0);
        @(negedge clk);
        chk("latency_upd", 32'(upd), 32'h1);
        chk("latency_digit0", 32'(digits[3:0]), 32'h2);
        chk("latency_valid", 32'(dig_valid), 32'h1);

        for (int i = 0; i < 4; i++) apply(vecs[i]);
        chk("scan_digits", 32'(digits), 32'h7531);
        chk("scan_valid", 32'(dig_valid), 32'hF);

        for (int i = 4; i < 11; i++) apply(vecs[i]);
        chk("table_digits", 32'(digits), 32'hEF81);

        // Blank then bad glyph with err_clr on the capture edge.
        sbq.push_back('{3, 4'hF, 1'b1});
        dig_sel_n = 4'b0111;
        seg_n     = 7'h7F;
        repeat (10) @(negedge clk);
        sbq.push_back('{3, 4'hE, 1'b1});
        seg_n = 7'h55;
        repeat (2 + STABLE_CYC) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("errclr_cap_upd", 32'(upd), 32'h1);
        chk("errclr_set_wins", 32'(err), 32'h1);
        repeat (4) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("errclr_clears", 32'(err), 32'h0);

        // Watchdog: last capture, then stop scanning.
        sbq.push_back('{0, 4'h1, 1'b0});
        dig_sel_n = 4'b1110;
        seg_n     = 7'h79;
        wait_upd("wd_cap_seen");
        dig_sel_n = 4'b1111;
        repeat (TIMEOUT - 1) @(negedge clk);
        chk("wd_not_yet_stale", 32'(stale), 32'h0);
        chk("wd_valid_before", 32'(dig_valid), 32'hF);
        @(negedge clk);
        chk("wd_stale", 32'(stale), 32'h1);
        chk("wd_valid_cleared", 32'(dig_valid), 32'h0);
        chk("wd_digits_kept", 32'(digits), 32'hEF81);
        repeat (5) @(negedge clk);

        sbq.push_back('{1, 4'h2, 1'b0});
        dig_sel_n = 4'b1101;
        seg_n     = 7'h24;
        wait_upd("wd_recap_seen");
        chk("wd_stale_clear", 32'(stale), 32'h0);
        chk("wd_valid_one", 32'(dig_valid), 32'h2);
        chk("wd_digits_new", 32'(digits), 32'hEF21);

        repeat (10) @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fnd_scan_decoder.md
Name: fnd_scan_decoder

Overview:
- Receive side of the 7-segment display interface: watches a multiplexed, active-low FND bus (segment lines plus digit selects) and rebuilds the 4-bit digit value shown on each position.
- Used in the doorlock test harness and self-check path to confirm that what is displayed matches the internal code, and to flag corrupted glyphs.
- Input glitches and scan transitions are rejected by a stability filter.
- A scan watchdog detects a display that has stopped refreshing.

Parameters:
- NUM_DIG, 4, number of multiplexed digit positions (1..8).
- STABLE_CYC, 4, consecutive identical synchronized samples needed before capture (2..255).
- TIMEOUT, 50000, cycles without any capture before all digits are declared stale (2..2^20-1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- seg_n  in  7  segment lines {g,f,e,d,c,b,a}, active-low (0 = lit).
- dig_sel_n  in  NUM_DIG  digit enables, active-low, one-hot when valid.
- err_clr  in  1  synchronous clear of sticky err.
- digits  out  4*NUM_DIG  decoded value per position; digit i is at bits [4i+3:4i].
- dig_valid  out  NUM_DIG  position i holds a captured value since the last reset or stale event.
- upd  out  1  one-cycle pulse on every capture.
- upd_idx  out  3  position index of the capture flagged by upd.
- err  out  1  sticky flag: an unknown glyph was captured.
- stale  out  1  high while the watchdog has expired.

Behaviour:
- Reset (rst_n low, asynchronous):
  - digits = all 0, dig_valid = 0, upd = 0, upd_idx = 0, err = 0, stale = 0.
  - Synchronizers clear to all-ones (inactive); counters clear to 0; FSM goes to IDLE.
- Input synchronization: seg_n and dig_sel_n each pass through a 2-flop synchronizer. All later logic uses only the synchronized pair (sel, seg).
- Decode table (seg, shown as {g..a} hex), applied at capture:
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 58→7, 00→8, 10→9.
  - 7F (blank) → F.
  - Any other pattern → E, and err is set.
- FSM:
  - IDLE: sel is not exactly one-hot (all ones, or more than one low). Stability counter held at 0.
  - TRACK: sel is one-hot. Each cycle, if (sel, seg) equals the previous cycle's pair, the counter increments; otherwise it reloads to 1. When the counter reaches STABLE_CYC, capture and go to HOLD.
  - HOLD: pair is unchanged; no further capture.
  - Any change of the pair: go to TRACK with counter = 1 if the new sel is one-hot, else go to IDLE.
- Capture, registered:
  - digits[idx] ← decoded value; dig_valid[idx] ← 1; upd = 1 for exactly one cycle; upd_idx = idx.
  - idx is the index of the low bit in sel.
  - Recapturing the same value still pulses upd.
- Latency: a pin pair held constant from edge E produces upd high in the cycle after edge E+2+STABLE_CYC. That is 2 cycles of synchronizer plus STABLE_CYC filter cycles.
- Glitch rejection: a pair held for fewer than STABLE_CYC synchronized cycles never captures, and digits are unchanged.
- err:
  - Set on capture of an unknown glyph. Cleared by err_clr.
  - If err_clr and a new unknown capture occur in the same cycle, set wins (err = 1).
- Watchdog:
  - Counter increments each cycle and resets to 0 on capture.
  - On reaching TIMEOUT: stale = 1, dig_valid cleared to all 0, digits retained. The counter saturates.
  - The next capture clears stale and sets only that position's dig_valid.
- NUM_DIG < 8: upd_idx upper bits read 0. A one-hot sel can only select bits below NUM_DIG.
- Reset asserted mid-capture: all outputs go to reset values immediately, with no upd pulse. After release, capture restarts from IDLE and needs full synchronizer plus filter latency.

Test Plan:
- Reset: hold rst_n low, drive seg_n=7'h24, dig_sel_n=4'b1110 → digits=0, dig_valid=0, upd=0, stale=0. Release, hold inputs → single upd with upd_idx=0, digits[3:0]=2, dig_valid=4'b0001, at the latency stated in Behaviour.
- Full scan: cycle positions 0..3 showing 1,3,5,7 (79,30,12,58), 10 cycles each → digits=16'h7531, dig_valid=4'hF, four upd pulses with idx 0,1,2,3.
- Glitch: with pos 1 holding 3, inject seg_n=7'h00 for STABLE_CYC-1 synchronized cycles → no upd, digits[7:4] stays 3. Inject it for STABLE_CYC cycles → upd, digits[7:4]=8.
- Blank and error: blank 7F on pos 2 → digits[11:8]=F, err=0. Pattern 7'h55 on pos 3 → digits[15:12]=E, err=1. err_clr and a second 55 capture in the same cycle → err stays 1.
- Invalid select: dig_sel_n=4'b1100 or 4'b1111 for 20 cycles with seg_n=00 → no upd.
- Watchdog: TIMEOUT=100, stop scanning → stale=1 and dig_valid=0 at cycle 100 after the last capture, digits retained. Next capture on pos 1 → stale=0, dig_valid=4'b0010.
